// File: rtl/demux_memoria_1x2_8bits.sv
// rtl/demux_memoria_1x2_8bits.sv - de-interleaves one word stream into two FWFT lane FIFOs
// Optional macro DEMUX_DROP_CNT_EN adds the saturating drop_count output.
module demux_memoria_1x2_8bits #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             pop0,
    input  logic             pop1,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             full0,
    output logic             full1,
`ifdef DEMUX_DROP_CNT_EN
    output logic             overflow,
    output logic [7:0]       drop_count
`else
    output logic             overflow
`endif
);

    localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    logic             r_sel;
    logic             r_overflow;
    logic [WIDTH-1:0] r_mem    [2][DEPTH];
    logic [AW-1:0]    r_rd_ptr [2];
    logic [AW-1:0]    r_wr_ptr [2];
    logic [AW:0]      r_count  [2];

    logic [1:0] w_pop_req;
    logic [1:0] w_valid;
    logic [1:0] w_full;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_wr;
    logic [1:0] w_drop;

    assign w_pop_req = {pop1, pop0};

    // A full lane still accepts a word when its head is popped in the same cycle.
    always_comb begin
        w_valid = '0;
        w_full  = '0;
        w_push  = '0;
        w_pop   = '0;
        w_wr    = '0;
        w_drop  = '0;
        for (int l = 0; l < 2; l++) begin
            w_valid[l] = (r_count[l] != '0);
            w_full[l]  = (r_count[l] == C_FULL);
            w_push[l]  = valid_in && (r_sel == 1'(l));
            w_pop[l]   = w_pop_req[l] && w_valid[l];
            w_wr[l]    = w_push[l] && (!w_full[l] || w_pop[l]);
            w_drop[l]  = w_push[l] && w_full[l] && !w_pop[l];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel      <= 1'b0;
            r_overflow <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                r_rd_ptr[l] <= '0;
                r_wr_ptr[l] <= '0;
                r_count[l]  <= '0;
            end
        end else begin
            // Select advances on every valid word, dropped or not, to stay aligned with the mux.
            if (valid_in) begin
                r_sel <= ~r_sel;
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
            for (int l = 0; l < 2; l++) begin
                if (w_wr[l]) begin
                    r_mem[l][r_wr_ptr[l]] <= data_in;
                    r_wr_ptr[l]           <= r_wr_ptr[l] + C_PTR_ONE;
                end
                if (w_pop[l]) begin
                    r_rd_ptr[l] <= r_rd_ptr[l] + C_PTR_ONE;
                end
                case ({w_wr[l], w_pop[l]})
                    2'b10:   r_count[l] <= r_count[l] + C_CNT_ONE;
                    2'b01:   r_count[l] <= r_count[l] - C_CNT_ONE;
                    default: r_count[l] <= r_count[l];
                endcase
            end
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= 8'h00;
        end else if ((|w_drop) && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'h01;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign data_out0  = w_valid[0] ? r_mem[0][r_rd_ptr[0]] : '0;
    assign data_out1  = w_valid[1] ? r_mem[1][r_rd_ptr[1]] : '0;
    assign valid_out0 = w_valid[0];
    assign valid_out1 = w_valid[1];
    assign full0      = w_full[0];
    assign full1      = w_full[1];
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_demux_memoria_1x2_8bits.sv
// tb/tb_demux_memoria_1x2_8bits.sv - table, directed and random checks against a queue model
module tb_demux_memoria_1x2_8bits;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       pop0 = 1'b0;
    logic       pop1 = 1'b0;
    logic [7:0] data_out0, data_out1;
    logic       valid_out0, valid_out1, full0, full1, overflow;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    demux_memoria_1x2_8bits #(.WIDTH(8), .DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .pop0(pop0), .pop1(pop1), .data_out0(data_out0), .data_out1(data_out1),
        .valid_out0(valid_out0), .valid_out1(valid_out1), .full0(full0), .full1(full1),
`ifdef DEMUX_DROP_CNT_EN
        .overflow(overflow), .drop_count(drop_count)
`else
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: two word queues, a lane pointer and the drop bookkeeping.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         m_lane = 0;
    logic       m_ovf = 1'b0;
    int         m_drops = 0;

    typedef struct {
        logic v, p0, p1;
        logic [7:0] d;
        logic ev0, ev1, ef0, ef1, eovf;
        logic [7:0] ed0, ed1;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic p0, input logic p1,
                              input logic rst);
        bit pe0, pe1, acc;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_lane = 0;
            m_ovf = 1'b0;
            m_drops = 0;
        end else begin
            pe0 = p0 && (q0.size() > 0);
            pe1 = p1 && (q1.size() > 0);
            acc = (m_lane == 0) ? ((q0.size() < DEPTH) || pe0) : ((q1.size() < DEPTH) || pe1);
            if (pe0) void'(q0.pop_front());
            if (pe1) void'(q1.pop_front());
            if (v) begin
                if (!acc) begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end else if (m_lane == 0) begin
                    q0.push_back(d);
                end else begin
                    q1.push_back(d);
                end
                m_lane = 1 - m_lane;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid_out0"}, valid_out0, q0.size() != 0);
        chk({tag, ".valid_out1"}, valid_out1, q1.size() != 0);
        chk({tag, ".full0"}, full0, q0.size() == DEPTH);
        chk({tag, ".full1"}, full1, q1.size() == DEPTH);
        chk({tag, ".overflow"}, overflow, m_ovf);
        if (q0.size() != 0) chk({tag, ".data_out0"}, data_out0, q0[0]);
        if (q1.size() != 0) chk({tag, ".data_out1"}, data_out1, q1[0]);
`ifdef DEMUX_DROP_CNT_EN
        chk({tag, ".drop_count"}, drop_count, m_drops);
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic p0,
                        input logic p1, input logic rst);
        valid_in = v;
        data_in  = d;
        pop0     = p0;
        pop1     = p1;
        reset    = rst;
        @(posedge clk);
        model_edge(v, d, p0, p1, rst);
        #1;
        check_model(tag);
    endtask

    initial begin
        tbl[0]  = '{1,0,0,8'h00, 1,0,0,0,0, 8'h00,8'h00};
        tbl[1]  = '{1,0,0,8'h01, 1,1,0,0,0, 8'h00,8'h01};
        tbl[2]  = '{1,0,0,8'h02, 1,1,0,0,0, 8'h00,8'h01};
        tbl[3]  = '{1,0,0,8'h03, 1,1,0,0,0, 8'h00,8'h01};
        tbl[4]  = '{1,0,0,8'h04, 1,1,0,0,0, 8'h00,8'h01};
        tbl[5]  = '{1,0,0,8'h05, 1,1,0,0,0, 8'h00,8'h01};
        tbl[6]  = '{1,0,0,8'h06, 1,1,1,0,0, 8'h00,8'h01};
        tbl[7]  = '{1,0,0,8'h07, 1,1,1,1,0, 8'h00,8'h01};
        tbl[8]  = '{1,0,0,8'h08, 1,1,1,1,1, 8'h00,8'h01};
        tbl[9]  = '{1,0,0,8'h09, 1,1,1,1,1, 8'h00,8'h01};
        tbl[10] = '{0,1,1,8'h00, 1,1,0,0,1, 8'h02,8'h03};
        tbl[11] = '{0,1,1,8'h00, 1,1,0,0,1, 8'h04,8'h05};
        tbl[12] = '{0,1,1,8'h00, 1,1,0,0,1, 8'h06,8'h07};
        tbl[13] = '{0,1,1,8'h00, 0,0,0,0,1, 8'h00,8'h00};

        // Reset state
        step("rst", 1, 8'hEE, 1, 1, 1);
        step("rst", 0, 8'h00, 0, 0, 1);
        chk("rst.data_out0", data_out0, 8'h00);
        chk("rst.data_out1", data_out1, 8'h00);

        // Interleave 01..04
        step("t1", 1, 8'h01, 0, 0, 0);
        chk("t1.v0_after_01", valid_out0, 1'b1);
        chk("t1.v1_after_01", valid_out1, 1'b0);
        step("t1", 1, 8'h02, 0, 0, 0);
        chk("t1.v1_after_02", valid_out1, 1'b1);
        step("t1", 1, 8'h03, 0, 0, 0);
        step("t1", 1, 8'h04, 0, 0, 0);
        chk("t1.head0", data_out0, 8'h01);
        chk("t1.head1", data_out1, 8'h02);
        step("t1", 0, 8'h00, 1, 1, 0);
        chk("t1.second0", data_out0, 8'h03);
        chk("t1.second1", data_out1, 8'h04);

        // Overfill table
        step("t2rst", 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 14; i++) begin
            step("t2", tbl[i].v, tbl[i].d, tbl[i].p0, tbl[i].p1, 1'b0);
            chk($sformatf("tbl%0d.valid_out0", i), valid_out0, tbl[i].ev0);
            chk($sformatf("tbl%0d.valid_out1", i), valid_out1, tbl[i].ev1);
            chk($sformatf("tbl%0d.full0", i), full0, tbl[i].ef0);
            chk($sformatf("tbl%0d.full1", i), full1, tbl[i].ef1);
            chk($sformatf("tbl%0d.overflow", i), overflow, tbl[i].eovf);
            if (tbl[i].ev0) chk($sformatf("tbl%0d.data_out0", i), data_out0, tbl[i].ed0);
            if (tbl[i].ev1) chk($sformatf("tbl%0d.data_out1", i), data_out1, tbl[i].ed1);
        end
`ifdef DEMUX_DROP_CNT_EN
        chk("t2.drop_count", drop_count, 8'd2);
`endif

        // Push onto full lane0 with simultaneous pop
        step("t3rst", 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 8; i++) step("t3fill", 1, 8'h10 + 8'(i), 0, 0, 0);
        chk("t3.full0_before", full0, 1'b1);
        step("t3", 1, 8'h20, 1, 0, 0);
        chk("t3.full0_after", full0, 1'b1);
        chk("t3.overflow", overflow, 1'b0);
        chk("t3.head0", data_out0, 8'h12);
        for (int i = 0; i < 3; i++) step("t3drain", 0, 8'h00, 1, 0, 0);
        chk("t3.last0", data_out0, 8'h20);

        // Idle gaps hold the lane select
        step("t4rst", 0, 8'h00, 0, 0, 1);
        step("t4", 1, 8'hAA, 0, 0, 0);
        step("t4", 0, 8'h00, 0, 0, 0);
        step("t4", 1, 8'hBB, 0, 0, 0);
        step("t4", 0, 8'h00, 0, 0, 0);
        step("t4", 1, 8'hCC, 0, 0, 0);
        chk("t4.head0", data_out0, 8'hAA);
        chk("t4.head1", data_out1, 8'hBB);
        step("t4", 0, 8'h00, 1, 0, 0);
        chk("t4.second0", data_out0, 8'hCC);

        // Mid-stream reset
        step("t5rst", 0, 8'h00, 0, 0, 1);
        step("t5", 1, 8'h31, 0, 0, 0);
        step("t5", 1, 8'h32, 0, 0, 0);
        step("t5", 1, 8'h33, 0, 0, 0);
        step("t5", 1, 8'h34, 0, 0, 1);
        chk("t5.valid_out0", valid_out0, 1'b0);
        chk("t5.valid_out1", valid_out1, 1'b0);
        step("t5", 1, 8'h55, 0, 0, 0);
        chk("t5.lane0_55", data_out0, 8'h55);
        chk("t5.lane1_empty", valid_out1, 1'b0);

        // Pop on empty lane, then push and pop
        step("t6rst", 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("t6idle", 0, 8'h00, 1, 0, 0);
        chk("t6.empty0", valid_out0, 1'b0);
        step("t6", 1, 8'hAB, 1, 0, 0);
        chk("t6.appears", valid_out0, 1'b1);
        chk("t6.data", data_out0, 8'hAB);
        step("t6", 0, 8'h00, 1, 0, 0);
        chk("t6.popped", valid_out0, 1'b0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 60) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
